data_memory_io: RTL

DATA_MEMORY_IO -- requirements
Module: data_memory_io

---
 rtl/data_memory_io.sv | 108 ++++++++++
 1 files changed

// File: rtl/data_memory_io.sv
// Data RAM plus memory-mapped display, button and switch ports for the CPU.
// Define DATA_MEMORY_IO_DEBOUNCE_EN to compile in the button debouncer.
module data_memory_io #(
    parameter int RAM_DEPTH       = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  DataAddr,
    input  logic [15:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [15:0] ReadData,
    input  logic [7:0]  Switches,
    input  logic        Button,
    output logic [15:0] Display
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [8:0] DEPTH9 = 9'(RAM_DEPTH);
    localparam logic [7:0] ADDR_DISP = 8'd253;
    localparam logic [7:0] ADDR_BTN  = 8'd254;
    localparam logic [7:0] ADDR_SW   = 8'd255;

    logic [15:0]   ram [RAM_DEPTH];
    logic [AW-1:0] idx;
    logic          ram_hit;
    logic          is_disp;
    logic          is_btn;
    logic          is_sw;

    logic [7:0] sw_meta;
    logic [7:0] sw_sync;
    logic       btn_meta;
    logic       btn_sync;
    logic       btn_stable;

    assign idx     = DataAddr[AW-1:0];
    assign ram_hit = {1'b0, DataAddr} < DEPTH9;
    assign is_disp = DataAddr == ADDR_DISP;
    assign is_btn  = DataAddr == ADDR_BTN;
    assign is_sw   = DataAddr == ADDR_SW;

    // RAM is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit)
            ram[idx] <= WriteData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Display <= '0;
        else if (MemWrite && is_disp)
            Display <= WriteData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= Switches;
            sw_sync  <= sw_meta;
            btn_meta <= Button;
            btn_sync <= btn_meta;
        end
    end

`ifdef DATA_MEMORY_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt;

    // a change is accepted only after DEBOUNCE_CYCLES mismatched edges in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            btn_stable <= 1'b0;
        end else if (btn_sync == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt >= CMAX) begin
            btn_stable <= btn_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end
`else
    assign btn_stable = btn_sync;
`endif

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            unique case (1'b1)
                ram_hit: ReadData = ram[idx];
                is_disp: ReadData = Display;
                is_btn:  ReadData = {15'b0, btn_stable};
                is_sw:   ReadData = {8'b0, sw_sync};
                default: ReadData = '0;
            endcase
        end
    end

endmodule
